// File: rtl/text_mode_renderer.sv
// Character-cell text renderer: text RAM + 8x8 font ROM lookup with a blinking block cursor.
// Fixed 4-clock pipeline, no stalls; de/hs/vs are delayed to stay aligned with pix.
module text_mode_renderer #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 60,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              de,
  input  logic              hs,
  input  logic              vs,
  output logic [ADDR_W-1:0] text_addr,
  input  logic [7:0]        text_data,
  output logic [7:0]        font_ch,
  input  logic [63:0]       font_bitmap,
  input  logic              cursor_en,
  input  logic [6:0]        cursor_col,
  input  logic [5:0]        cursor_row,
  output logic              pix,
  output logic              de_o,
  output logic              hs_o,
  output logic              vs_o
);

  localparam int unsigned     FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
  localparam logic [15:0]     COLS_W  = 16'(COLS);
  localparam logic [15:0]     ROWS_W  = 16'(ROWS);

  typedef struct packed {
    logic [2:0] px;
    logic [2:0] py;
    logic       in_range;
    logic       cursor_hit;
    logic       de;
    logic       hs;
    logic       vs;
  } stage_t;

  logic [6:0]        col;
  logic [6:0]        row;
  logic              in_range;
  logic [15:0]       addr_full;
  logic [ADDR_W-1:0] text_addr_q, text_addr_d;
  stage_t            s1_q, s1_d, s2_q, s3_q;
  logic              pix_q, pix_d;
  logic              de_o_q, hs_o_q, vs_o_q;
  logic              vs_q;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic              blink_q, blink_d;

  always_comb begin
    col         = x[9:3];
    row         = y[9:3];
    in_range    = ({9'd0, col} < COLS_W) && ({9'd0, row} < ROWS_W);
    addr_full   = {9'd0, row} * COLS_W + {9'd0, col};
    text_addr_d = in_range ? ADDR_W'(addr_full) : '0;

    s1_d            = '0;
    s1_d.px         = x[2:0];
    s1_d.py         = y[2:0];
    s1_d.in_range   = in_range;
    s1_d.cursor_hit = cursor_en && (col == cursor_col) && (row == {1'b0, cursor_row});
    s1_d.de         = de;
    s1_d.hs         = hs;
    s1_d.vs         = vs;

    // Byte 7 is the top glyph row, so (7-py)*8+px reduces to {~py, px}.
    pix_d = s3_q.de && s3_q.in_range &&
            (font_bitmap[{~s3_q.py, s3_q.px}] ^ (s3_q.cursor_hit && blink_q));

    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (vs && !vs_q) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      text_addr_q <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      pix_q       <= 1'b0;
      de_o_q      <= 1'b0;
      hs_o_q      <= 1'b0;
      vs_o_q      <= 1'b0;
      vs_q        <= 1'b0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      text_addr_q <= text_addr_d;
      s1_q        <= s1_d;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      pix_q       <= pix_d;
      de_o_q      <= s3_q.de;
      hs_o_q      <= s3_q.hs;
      vs_o_q      <= s3_q.vs;
      vs_q        <= vs;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign text_addr = text_addr_q;
  assign font_ch   = text_data;
  assign pix       = pix_q;
  assign de_o      = de_o_q;
  assign hs_o      = hs_o_q;
  assign vs_o      = vs_o_q;

endmodule
